// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch mm:ss counter.
// Optional lap freeze in the top is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX     = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59 with increment, synchronous clear
// and a carry that fires on the 59 -> 00 increment.
module bcd_mod60
  import stopwatch_pkg::*;
#(
  parameter bcd_t TENS_MAX = SEC_TENS_MAX
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output bcd_t o_tens,
  output bcd_t o_ones,
  output logic o_carry
);

  bcd_t r_tens;
  bcd_t r_ones;
  logic w_ones_max;
  logic w_tens_max;

  assign w_ones_max = (r_ones == ONES_MAX);
  assign w_tens_max = (r_tens == TENS_MAX);
  assign o_carry    = i_inc && w_ones_max && w_tens_max;
  assign o_tens     = r_tens;
  assign o_ones     = r_ones;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_ones_max) begin
        r_ones <= '0;
        r_tens <= w_tens_max ? '0 : r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base and BCD mm:ss counter with pause, clear and adjust.
// Define STOPWATCH_LAP_EN to add the lap display-freeze feature.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int ADJ_DIV  = 50_000_000
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic pause,
  input  logic clr,
  input  logic adj,
  input  logic sel,
  input  logic lap,
  output bcd_t digit1,
  output bcd_t digit2,
  output bcd_t digit3,
  output bcd_t digit4,
  output logic running
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ADJ_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [AW-1:0] r_adj_cnt;
  logic          r_run;
  logic          w_tick_en;
  logic          w_tick;
  logic          w_adj_tick;
  logic          w_sec_inc;
  logic          w_min_inc;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic [15:0]   w_count;
  bcd_t          w_m10, w_m1, w_s10, w_s1;

  assign w_tick_en  = r_run && !adj;
  assign w_tick     = w_tick_en && (r_tick_cnt == TICK_LAST);
  assign w_adj_tick = adj && (r_adj_cnt == ADJ_LAST);
  // Adjust steps one field only; the count carry is gated by w_tick.
  assign w_sec_inc  = !clr && (w_tick || (w_adj_tick && sel));
  assign w_min_inc  = !clr && ((w_tick && w_sec_carry) ||
                               (w_adj_tick && !sel));

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_adj_cnt  <= '0;
      r_run      <= 1'b0;
    end else if (clr) begin
      r_tick_cnt <= '0;
      r_adj_cnt  <= '0;
      r_run      <= 1'b0;
    end else begin
      if (w_tick_en)
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (!adj)
        r_adj_cnt <= '0;
      else
        r_adj_cnt <= w_adj_tick ? '0 : r_adj_cnt + AW'(1);
      if (!adj && pause)
        r_run <= !r_run;
    end
  end

  bcd_mod60 #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
    .i_clk   (clk100MHz),
    .i_rst   (rst),
    .i_inc   (w_sec_inc),
    .i_clr   (clr),
    .o_tens  (w_s10),
    .o_ones  (w_s1),
    .o_carry (w_sec_carry)
  );

  bcd_mod60 #(.TENS_MAX(MIN_TENS_MAX)) u_min (
    .i_clk   (clk100MHz),
    .i_rst   (rst),
    .i_inc   (w_min_inc),
    .i_clr   (clr),
    .o_tens  (w_m10),
    .o_ones  (w_m1),
    .o_carry (w_min_carry)
  );

  assign w_count = {w_m10, w_m1, w_s10, w_s1};
  assign running = r_run;

`ifdef STOPWATCH_LAP_EN
  logic        r_adj_d;
  logic        r_frz;
  logic [15:0] r_lap;
  logic [15:0] w_disp;

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_adj_d <= 1'b0;
      r_frz   <= 1'b0;
      r_lap   <= '0;
    end else begin
      r_adj_d <= adj;
      if (clr || (adj && !r_adj_d)) begin
        r_frz <= 1'b0;
      end else if (lap && r_run) begin
        r_frz <= !r_frz;
        if (!r_frz)
          r_lap <= w_count;
      end
    end
  end

  assign w_disp = r_frz ? r_lap : w_count;
  assign {digit1, digit2, digit3, digit4} = w_disp;
  logic w_unused;
  assign w_unused = w_min_carry;
`else
  logic w_unused;
  assign w_unused = lap ^ w_min_carry;
  assign {digit1, digit2, digit3, digit4} = w_count;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: vector table, corner sequences and a
// randomized run against a seconds-based reference model.
module tb_stopwatch_counter;

  localparam int TICK_DIV = 4;
  localparam int ADJ_DIV  = 2;

  logic clk = 1'b0;
  logic rst, pause, clr, adj, sel, lap;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic running;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV)) dut (
    .clk100MHz (clk),
    .rst       (rst),
    .pause     (pause),
    .clr       (clr),
    .adj       (adj),
    .sel       (sel),
    .lap       (lap),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .digit4    (digit4),
    .running   (running)
  );

  // Reference model: time held as total seconds 0..3599
  int m_t, m_ph, m_aph, m_lapt;
  bit m_run, m_frz, m_adjd;

  function automatic void model_reset();
    m_t = 0; m_ph = 0; m_aph = 0; m_lapt = 0;
    m_run = 0; m_frz = 0; m_adjd = 0;
  endfunction

  function automatic void model_step();
    int  t_old;
    bit  run_old;
    t_old   = m_t;
    run_old = m_run;
    if (clr) begin
      m_t = 0; m_run = 0; m_ph = 0; m_aph = 0; m_frz = 0;
    end else if (adj) begin
      if (m_aph == ADJ_DIV - 1) begin
        m_aph = 0;
        if (sel)
          m_t = (m_t / 60) * 60 + ((m_t % 60) + 1) % 60;
        else
          m_t = (((m_t / 60) + 1) % 60) * 60 + (m_t % 60);
      end else begin
        m_aph++;
      end
`ifdef STOPWATCH_LAP_EN
      if (!m_adjd) m_frz = 0;
      else if (lap && run_old) begin
        if (!m_frz) m_lapt = t_old;
        m_frz = !m_frz;
      end
`endif
    end else begin
      m_aph = 0;
      if (m_run) begin
        if (m_ph == TICK_DIV - 1) begin
          m_ph = 0;
          m_t = (m_t + 1) % 3600;
        end else begin
          m_ph++;
        end
      end
      if (pause) m_run = !m_run;
`ifdef STOPWATCH_LAP_EN
      if (lap && run_old) begin
        if (!m_frz) m_lapt = t_old;
        m_frz = !m_frz;
      end
`endif
    end
    m_adjd = adj;
  endfunction

  function automatic logic [16:0] model_out();
    int v;
    v = m_frz ? m_lapt : m_t;
    return {4'(v / 600), 4'((v / 60) % 10),
            4'((v % 60) / 10), 4'(v % 10), m_run};
  endfunction

  function automatic logic [16:0] dut_out();
    return {digit1, digit2, digit3, digit4, running};
  endfunction

  task automatic check(input string nm, input logic [16:0] act,
                       input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s: got %h_%b want %h_%b",
                 nm, act[16:1], act[0], exp[16:1], exp[0]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          p, c, a, s;
    int          n;
    logic [15:0] d;
    bit          r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit p, bit c, bit a, bit s, int n,
                              logic [15:0] d, bit r);
    vec_t v;
    v.p = p; v.c = c; v.a = a; v.s = s; v.n = n; v.d = d; v.r = r;
    return v;
  endfunction

  initial begin
    logic [15:0] lap_exp;
    rst = 1'b1; pause = 0; clr = 0; adj = 0; sel = 0; lap = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", dut_out(), 17'h0);
    rst = 1'b0;

    tbl.push_back(mk(0,0,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0000, 1));
    tbl.push_back(mk(0,0,0,0, 40, 16'h0010, 1));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0010, 0));
    tbl.push_back(mk(0,0,0,0, 20, 16'h0010, 0));
    tbl.push_back(mk(0,0,1,1,  6, 16'h0013, 0));
    tbl.push_back(mk(0,0,1,0,  4, 16'h0213, 0));
    tbl.push_back(mk(0,1,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(0,0,1,1,118, 16'h0059, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0059, 1));
    tbl.push_back(mk(0,0,0,0,  4, 16'h0100, 1));
    tbl.push_back(mk(0,1,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(0,0,1,1,118, 16'h0059, 0));
    tbl.push_back(mk(0,0,1,0,118, 16'h5959, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h5959, 1));
    tbl.push_back(mk(0,0,0,0,  4, 16'h0000, 1));
    tbl.push_back(mk(0,1,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(0,0,1,0, 24, 16'h1200, 0));
    tbl.push_back(mk(0,0,1,1, 68, 16'h1234, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h1234, 1));
    tbl.push_back(mk(0,0,0,0,  2, 16'h1234, 1));
    tbl.push_back(mk(1,1,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(1,0,1,1,  2, 16'h0001, 0));
    tbl.push_back(mk(0,1,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0000, 1));
    tbl.push_back(mk(0,0,0,0,  2, 16'h0000, 1));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0000, 0));
    tbl.push_back(mk(0,0,0,0, 20, 16'h0000, 0));
    tbl.push_back(mk(1,0,0,0,  1, 16'h0000, 1));
    tbl.push_back(mk(0,0,0,0,  1, 16'h0001, 1));

    foreach (tbl[i]) begin
      pause = tbl[i].p; clr = tbl[i].c;
      adj = tbl[i].a; sel = tbl[i].s;
      step();
      pause = 0; clr = 0;
      for (int k = 1; k < tbl[i].n; k++) step();
      check($sformatf("vec%0d", i), dut_out(), {tbl[i].d, tbl[i].r});
    end
    adj = 0;

    // Asynchronous reset between clock edges
    clr = 1; step(); clr = 0;
    pause = 1; step(); pause = 0;
    repeat (6) step();
    #2 rst = 1'b1;
    #1 check("async_rst", dut_out(), 17'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Lap freeze and release
    pause = 1; step(); pause = 0;
    repeat (12) step();
    check("pre_lap", dut_out(), {16'h0003, 1'b1});
    lap = 1; step(); lap = 0;
    repeat (7) step();
`ifdef STOPWATCH_LAP_EN
    lap_exp = 16'h0003;
`else
    lap_exp = 16'h0005;
`endif
    check("lap_frozen", dut_out(), {lap_exp, 1'b1});
    lap = 1; step(); lap = 0;
    check("lap_release", dut_out(), {16'h0005, 1'b1});

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      pause = ($urandom % 6) == 0;
      clr   = ($urandom % 97) == 0;
      lap   = ($urandom % 8) == 0;
      if (($urandom % 40) == 0) adj = !adj;
      if (($urandom % 10) == 0) sel = 1'($urandom % 2);
      step();
      check("random", dut_out(), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
